// File: rtl/core_common_pkg.sv
// Shared payload types carried through the pipeline's elastic buffers.
// The decode, rename and issue stages all exchange these packets.
package core_common_pkg;

    typedef struct packed {
        logic [3:0] tag;
        logic [7:0] value;
    } uop_t;

    // A uop whose tag is taken from the low nibble of its value.
    function automatic uop_t make_uop(input logic [7:0] value);
        uop_t u;
        u.tag   = value[3:0];
        u.value = value;
        return u;
    endfunction

endpackage

// File: rtl/elastic_buffer_struct.sv
// Circular-array elastic buffer for a generic payload type, with flush on mispredict.
// ready_in, valid_out, data_out and almost_full are driven purely from registered state.
module elastic_buffer_struct #(
    parameter type T        = logic,
    parameter int  DEPTH    = 4,
    parameter int  AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mispredict,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  T                           data_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output T                           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    import core_common_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enq;
    logic             deq;

    assign ready_in    = (count != CNT_W'(DEPTH));
    assign valid_out   = (count != '0);
    assign data_out    = mem[head];
    assign almost_full = (count >= CNT_W'(AF_LEVEL));

    assign enq = valid_in && ready_in;
    assign deq = valid_out && ready_out;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; it is only observed through valid_out.
    always_ff @(posedge clk) begin
        if (enq && !mispredict) mem[tail] <= data_in;
    end

endmodule
